// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: write-side controller for the register bank's single write port.
// Merges GPR writeback requests from the pipeline WB stage (fixed priority) and the
// late load return into a small in-order FIFO. It issues at most one registered bank
// write per cycle and reports in-flight writes to the hazard unit.
// Optional build macro: REG_INIT_SWEEP_EN. When it is defined, reset release starts a
// sweep that writes 0 to registers 1..31 before normal operation begins.
//
// state | meaning
// SWEEP | post-reset init sweep, writing 0 to regs 1..31, no requests accepted
// RUN   | normal operation: accept requests, pop one queued write per cycle
module reg_write_ctrl #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [ADDR_WIDTH-1:0] wb_reg,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_reg,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic [ADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] chk_reg1,
   input  logic [ADDR_WIDTH-1:0] chk_reg2,
   output logic                  pending1,
   output logic                  pending2,
   output logic                  sweep_busy
);

   localparam int                  PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_REG = '1;

   typedef enum logic {SWEEP, RUN} state_t;

`ifdef REG_INIT_SWEEP_EN
   localparam state_t INIT_STATE = SWEEP;
`else
   localparam state_t INIT_STATE = RUN;
`endif

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   fifo_reg  [DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_data [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W:0]          count;

   logic                    in_run;
   logic                    has_room;
   logic                    wb_acc;
   logic                    ld_acc;
   logic                    push_en;
   logic                    pop_en;
   logic [ADDR_WIDTH-1:0]   push_reg;
   logic [DATA_WIDTH-1:0]   push_data;
   logic [DEPTH-1:0]        entry_valid;
   logic [PTR_W-1:0]        offset;
   logic                    hit1;
   logic                    hit2;

   assign in_run   = (state == RUN);
   assign has_room = (count < FULL_CNT);
   assign wb_ready = in_run && has_room;
   assign ld_ready = in_run && has_room && !wb_valid;
   assign wb_acc   = wb_valid && wb_ready;
   assign ld_acc   = ld_valid && ld_ready;

   // Register 0 is hardwired, so its requests complete the handshake but are dropped.
   assign push_reg  = wb_acc ? wb_reg  : ld_reg;
   assign push_data = wb_acc ? wb_data : ld_data;
   assign push_en   = (wb_acc || ld_acc) && (push_reg != '0);
   assign pop_en    = in_run && (count != '0);

`ifdef REG_INIT_SWEEP_EN
   assign sweep_busy = (state == SWEEP);
`else
   assign sweep_busy = 1'b0;
`endif

   // Entry i is live when its distance from the read pointer is below count.
   always_comb begin
      entry_valid = '0;
      offset      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - rd_ptr;
         entry_valid[i] = ({1'b0, offset} < count);
      end
   end

   // Hazard match against queued entries and the write currently on the outputs.
   always_comb begin
      hit1 = reg_write && (write_reg == chk_reg1);
      hit2 = reg_write && (write_reg == chk_reg2);
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (fifo_reg[i] == chk_reg1)) hit1 = 1'b1;
         if (entry_valid[i] && (fifo_reg[i] == chk_reg2)) hit2 = 1'b1;
      end
   end

   // During the sweep every nonzero register is about to be overwritten.
   assign pending1 = (chk_reg1 != '0) && (!in_run || hit1);
   assign pending2 = (chk_reg2 != '0) && (!in_run || hit2);

   // FIFO storage; left unreset because stale contents are masked by count.
   always_ff @(posedge clock) begin
      if (push_en) begin
         fifo_reg[wr_ptr]  <= push_reg;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   // Controller FSM: sweep sequencing, pointer/count bookkeeping and registered bank outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= INIT_STATE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
`ifdef REG_INIT_SWEEP_EN
         if (state == SWEEP) begin
            if (write_reg == LAST_REG) begin
               state     <= RUN;
               reg_write <= 1'b0;
            end else begin
               reg_write  <= 1'b1;
               write_reg  <= write_reg + 1'b1;
               write_data <= '0;
            end
         end else
`endif
         begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en) begin
               write_reg  <= fifo_reg[rd_ptr];
               write_data <= fifo_data[rd_ptr];
               reg_write  <= 1'b1;
               rd_ptr     <= rd_ptr + 1'b1;
            end else begin
               reg_write  <= 1'b0;
            end
            count <= count + (PTR_W+1)'(push_en) - (PTR_W+1)'(pop_en);
         end
      end
   end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Testbench for reg_write_ctrl: directed scenarios plus randomized traffic, checked
// against a queue-based reference model and an output scoreboard.
module tb_reg_write_ctrl;
   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
`ifdef REG_INIT_SWEEP_EN
   localparam int SWEEP_CYCLES = 32;
`else
   localparam int SWEEP_CYCLES = 0;
`endif

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          wb_valid = 1'b0, ld_valid = 1'b0;
   logic          wb_ready, ld_ready;
   logic [AW-1:0] wb_reg = '0, ld_reg = '0, chk_reg1 = '0, chk_reg2 = '0;
   logic [DW-1:0] wb_data = '0, ld_data = '0;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;
   logic          reg_write, pending1, pending2, sweep_busy;

   always #5 clock = ~clock;

   reg_write_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
      .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
      .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
      .pending1(pending1), .pending2(pending2), .sweep_busy(sweep_busy)
   );

   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           mq[$];      // model: accepted writes not yet issued
   wr_t           exp_q[$];   // scoreboard: expected bank writes in order
   logic          out_valid_m = 1'b0;
   logic [AW-1:0] out_reg_m = '0;
   int            sweep_left = SWEEP_CYCLES;
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return (sweep_left == 0) && (mq.size() < DEPTH);
   endfunction

   function automatic bit m_pending(input logic [AW-1:0] c);
      if (c == 0) return 1'b0;
      if (sweep_left > 0) return 1'b1;
      foreach (mq[i]) if (mq[i].r == c) return 1'b1;
      return out_valid_m && (out_reg_m == c);
   endfunction

   function automatic logic [AW-1:0] pick_reg();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return AW'(24);
         2: return AW'(3);
         default: return AW'($urandom_range(0, 31));
      endcase
   endfunction

   // One clock of stimulus: drive, check combinational outputs against the model, then advance the model at the edge.
   task automatic drive(input bit wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input bit lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                        input logic [AW-1:0] c1, input logic [AW-1:0] c2);
      bit  wacc, lacc;
      wr_t w;
      @(negedge clock);
      wb_valid = wv; wb_reg = wr; wb_data = wd;
      ld_valid = lv; ld_reg = lr; ld_data = ld;
      chk_reg1 = c1; chk_reg2 = c2;
      #1;
      check("wb_ready", wb_ready, m_ready());
      check("ld_ready", ld_ready, m_ready() && !wv);
      check("pending1", pending1, m_pending(c1));
      check("pending2", pending2, m_pending(c2));
      check("reg_write", reg_write, out_valid_m);
      check("sweep_busy", sweep_busy, sweep_left > 0);
      wacc = wv && m_ready();
      lacc = lv && m_ready() && !wv;
      @(posedge clock);
      if (sweep_left > 0) begin
         if (sweep_left > 1) begin
            w = wr_t'{r: AW'(SWEEP_CYCLES + 1 - sweep_left), d: '0};
            exp_q.push_back(w);
            out_valid_m = 1'b1;
            out_reg_m   = w.r;
         end else begin
            out_valid_m = 1'b0;
         end
         sweep_left--;
      end else begin
         if (mq.size() > 0) begin
            w = mq.pop_front();
            exp_q.push_back(w);
            out_valid_m = 1'b1;
            out_reg_m   = w.r;
         end else begin
            out_valid_m = 1'b0;
         end
         if (wacc && wr != 0)      mq.push_back(wr_t'{r: wr, d: wd});
         else if (lacc && lr != 0) mq.push_back(wr_t'{r: lr, d: ld});
      end
   endtask

   task automatic idle(input int n, input logic [AW-1:0] c1, input logic [AW-1:0] c2);
      for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, c1, c2);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse();
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("rst_reg_write", reg_write, 0);
      check("rst_write_reg", write_reg, 0);
      check("rst_write_data", write_data, 0);
      mq.delete();
      exp_q.delete();
      out_valid_m = 1'b0;
      sweep_left  = SWEEP_CYCLES;
      wb_valid = 1'b0;
      ld_valid = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
   endtask

   // Monitor: every bank write must match the head of the scoreboard.
   initial begin
      wr_t w;
      forever begin
         @(negedge clock);
         if (reset_n && reg_write) begin
            if (exp_q.size() == 0) begin
               check("spurious_write", write_reg, '1);
            end else begin
               w = exp_q.pop_front();
               check("write_reg", write_reg, w.r);
               check("write_data", write_data, w.d);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      idle(SWEEP_CYCLES + 1, 5'd7, 5'd0);

      // Single write with hazard tracking on reg 10.
      drive(1, 5'd10, 32'd1, 0, '0, '0, 5'd10, 5'd0);
      idle(3, 5'd10, 5'd0);

      // Pipeline priority over the load return.
      for (int i = 1; i <= 6; i++)
         drive(1, AW'(i), $urandom, 1, 5'd24, 32'h24_0000, AW'(i), 5'd24);
      drive(0, '0, '0, 1, 5'd24, 32'h24_0000, 5'd24, 5'd6);
      idle(3, 5'd24, 5'd6);

      // Dense traffic from both sources.
      for (int i = 0; i < 20; i++)
         drive(i % 3 != 0, AW'(i + 1), $urandom, 1, AW'(31 - i), $urandom, AW'(i + 1), AW'(31 - i));
      idle(3, 5'd2, 5'd3);

      // Register 0 requests are consumed but never written.
      drive(1, 5'd0, 32'hDEADBEEF, 0, '0, '0, 5'd0, 5'd0);
      drive(0, '0, '0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
      idle(2, 5'd0, 5'd0);

      // Two writes to the same register land in acceptance order.
      drive(1, 5'd24, 32'd2, 0, '0, '0, 5'd24, 5'd0);
      drive(1, 5'd24, 32'd3, 0, '0, '0, 5'd24, 5'd0);
      idle(3, 5'd24, 5'd0);

      // Reset while writes are queued and one is on the outputs.
      drive(1, 5'd11, 32'hA, 0, '0, '0, 5'd11, 5'd12);
      drive(1, 5'd12, 32'hB, 0, '0, '0, 5'd11, 5'd12);
      drive(0, '0, '0, 1, 5'd13, 32'hC, 5'd13, 5'd12);
      reset_pulse();
      idle(SWEEP_CYCLES + 4, 5'd12, 5'd13);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 1), pick_reg(), $urandom, $urandom_range(0, 1), pick_reg(), $urandom,
               pick_reg(), pick_reg());

      idle(6, 5'd24, 5'd3);
      check("unissued_writes", exp_q.size(), 0);
      check("model_drained", mq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
